// File: rtl/alu_md_unit.sv
// Execute-stage ALU with an iterative multiply/divide unit and architectural HI/LO.
// Optional MADD/MADDU/MSUB/MSUBU accumulate support is enabled by defining ALU_MADD_EN.
module alu_md_unit #(
    parameter int  WIDTH   = 32,
    parameter int  MUL_LAT = 2,
    localparam int SAW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [7:0]       alucontrol_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic [SAW-1:0]   sa_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o,
    output logic             trap_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam logic [7:0] AND_CONTROL  = 8'h01, OR_CONTROL    = 8'h02, XOR_CONTROL  = 8'h03;
    localparam logic [7:0] NOR_CONTROL  = 8'h04, ADD_CONTROL   = 8'h05, ADDU_CONTROL = 8'h06;
    localparam logic [7:0] SUB_CONTROL  = 8'h07, SUBU_CONTROL  = 8'h08, SLT_CONTROL  = 8'h09;
    localparam logic [7:0] SLTU_CONTROL = 8'h0A, SLL_CONTROL   = 8'h0B, SRL_CONTROL  = 8'h0C;
    localparam logic [7:0] SRA_CONTROL  = 8'h0D, SLLV_CONTROL  = 8'h0E, SRLV_CONTROL = 8'h0F;
    localparam logic [7:0] SRAV_CONTROL = 8'h10, LUI_CONTROL   = 8'h11, CLO_CONTROL  = 8'h12;
    localparam logic [7:0] CLZ_CONTROL  = 8'h13, MOVN_CONTROL  = 8'h14, MOVZ_CONTROL = 8'h15;
    localparam logic [7:0] TEQ_CONTROL  = 8'h16, TNE_CONTROL   = 8'h17, TGE_CONTROL  = 8'h18;
    localparam logic [7:0] TGEU_CONTROL = 8'h19, TLT_CONTROL   = 8'h1A, TLTU_CONTROL = 8'h1B;
    localparam logic [7:0] MFHI_CONTROL = 8'h1C, MFLO_CONTROL  = 8'h1D, MTHI_CONTROL = 8'h1E;
    localparam logic [7:0] MTLO_CONTROL = 8'h1F, MULT_CONTROL  = 8'h20, MULTU_CONTROL = 8'h21;
    localparam logic [7:0] DIV_CONTROL  = 8'h22, DIVU_CONTROL  = 8'h23;
`ifdef ALU_MADD_EN
    localparam logic [7:0] MADD_CONTROL = 8'h24, MADDU_CONTROL = 8'h25;
    localparam logic [7:0] MSUB_CONTROL = 8'h26, MSUBU_CONTROL = 8'h27;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic [SAW:0] clz(input logic [WIDTH-1:0] v);
        logic [SAW:0] n;
        logic         found;
        n = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) n = n + 1'b1;
        end
        return n;
    endfunction

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]        sum, diff;
    assign a_s  = src_a_i;
    assign b_s  = src_b_i;
    assign sum  = src_a_i + src_b_i;
    assign diff = src_a_i - src_b_i;

    state_t             state_q, state_d;
    logic [SAW:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               sgn_q, sgn_d, div_q, div_d;
`ifdef ALU_MADD_EN
    logic               acc_q, acc_d, sub_q, sub_d;
`endif

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        trap_o     = 1'b0;
        case (alucontrol_i)
            AND_CONTROL:  result_o = src_a_i & src_b_i;
            OR_CONTROL:   result_o = src_a_i | src_b_i;
            XOR_CONTROL:  result_o = src_a_i ^ src_b_i;
            NOR_CONTROL:  result_o = ~(src_a_i | src_b_i);
            ADD_CONTROL: begin
                result_o   = sum;
                overflow_o = (src_a_i[WIDTH-1] == src_b_i[WIDTH-1]) && (sum[WIDTH-1] != src_a_i[WIDTH-1]);
            end
            ADDU_CONTROL: result_o = sum;
            SUB_CONTROL: begin
                result_o   = diff;
                overflow_o = (src_a_i[WIDTH-1] != src_b_i[WIDTH-1]) && (diff[WIDTH-1] != src_a_i[WIDTH-1]);
            end
            SUBU_CONTROL: result_o = diff;
            SLT_CONTROL:  result_o = {{(WIDTH-1){1'b0}}, a_s < b_s};
            SLTU_CONTROL: result_o = {{(WIDTH-1){1'b0}}, src_a_i < src_b_i};
            SLL_CONTROL:  result_o = src_b_i << sa_i;
            SRL_CONTROL:  result_o = src_b_i >> sa_i;
            SRA_CONTROL:  result_o = b_s >>> sa_i;
            SLLV_CONTROL: result_o = src_b_i << src_a_i[SAW-1:0];
            SRLV_CONTROL: result_o = src_b_i >> src_a_i[SAW-1:0];
            SRAV_CONTROL: result_o = b_s >>> src_a_i[SAW-1:0];
            LUI_CONTROL:  result_o = {src_b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            CLO_CONTROL:  result_o = {{(WIDTH-SAW-1){1'b0}}, clz(~src_a_i)};
            CLZ_CONTROL:  result_o = {{(WIDTH-SAW-1){1'b0}}, clz(src_a_i)};
            // The write-enable decision for conditional moves lives outside the ALU.
            MOVN_CONTROL, MOVZ_CONTROL: result_o = src_a_i;
            TEQ_CONTROL:  trap_o = (src_a_i == src_b_i);
            TNE_CONTROL:  trap_o = (src_a_i != src_b_i);
            TGE_CONTROL:  trap_o = (a_s >= b_s);
            TGEU_CONTROL: trap_o = (src_a_i >= src_b_i);
            TLT_CONTROL:  trap_o = (a_s < b_s);
            TLTU_CONTROL: trap_o = (src_a_i < src_b_i);
            MFHI_CONTROL: result_o = hi_q;
            MFLO_CONTROL: result_o = lo_q;
            default: ;
        endcase
    end

    logic is_mul, is_div, is_sgn, start;
    always_comb begin
        is_mul = (alucontrol_i == MULT_CONTROL) || (alucontrol_i == MULTU_CONTROL);
        is_sgn = (alucontrol_i == MULT_CONTROL) || (alucontrol_i == DIV_CONTROL);
`ifdef ALU_MADD_EN
        is_mul = is_mul || (alucontrol_i == MADD_CONTROL) || (alucontrol_i == MADDU_CONTROL)
                        || (alucontrol_i == MSUB_CONTROL) || (alucontrol_i == MSUBU_CONTROL);
        is_sgn = is_sgn || (alucontrol_i == MADD_CONTROL) || (alucontrol_i == MSUB_CONTROL);
`endif
        is_div = (alucontrol_i == DIV_CONTROL) || (alucontrol_i == DIVU_CONTROL);
        // Gating with rst keeps stall_o low while reset is asserted.
        start  = rst && valid_i && !flush_i && (state_q == S_IDLE) && (is_mul || is_div);
    end

    logic [2*WIDTH-1:0] prod, md_res;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [WIDTH:0]     shifted, trial;
    assign prod = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    always_comb begin
        q_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
        r_fix = (sgn_q && a_q[WIDTH-1]) ? -rem_q : rem_q;
        if (div_q) md_res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
`ifdef ALU_MADD_EN
        else if (acc_q) md_res = sub_q ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
        else md_res = prod;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        div_d   = div_q;
`ifdef ALU_MADD_EN
        acc_d   = acc_q;
        sub_d   = sub_q;
`endif
        stall_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall_o = 1'b1;
                    a_d     = src_a_i;
                    b_d     = src_b_i;
                    sgn_d   = is_sgn;
                    div_d   = is_div;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = (is_sgn && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
                    dsr_d   = (is_sgn && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
`ifdef ALU_MADD_EN
                    acc_d   = !(alucontrol_i == MULT_CONTROL || alucontrol_i == MULTU_CONTROL);
                    sub_d   = (alucontrol_i == MSUB_CONTROL) || (alucontrol_i == MSUBU_CONTROL);
`endif
                    if (is_div)            state_d = S_DIV;
                    else if (MUL_LAT == 1) state_d = S_DONE;
                    else                   state_d = S_MUL;
                end else if (valid_i && !flush_i) begin
                    if (alucontrol_i == MTHI_CONTROL) hi_d = src_a_i;
                    if (alucontrol_i == MTLO_CONTROL) lo_d = src_a_i;
                end
            end
            S_MUL: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == (SAW+1)'(MUL_LAT - 2)) state_d = S_DONE;
            end
            S_DIV: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // Restoring step: keep the trial difference only when it did not borrow.
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == (SAW+1)'(WIDTH - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush_i) {hi_d, lo_d} = md_res;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            stall_o = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            div_q   <= 1'b0;
`ifdef ALU_MADD_EN
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            div_q   <= div_d;
`ifdef ALU_MADD_EN
            acc_q   <= acc_d;
            sub_q   <= sub_d;
`endif
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: tb/tb_alu_md_unit.sv
// Directed-vector bench for alu_md_unit (WIDTH=32, MUL_LAT=2); covers ALU_MADD_EN either way.
module tb_alu_md_unit;
    localparam logic [7:0] AND_C = 8'h01, NOR_C = 8'h04, ADD_C = 8'h05, ADDU_C = 8'h06;
    localparam logic [7:0] SUB_C = 8'h07, SLT_C = 8'h09, SLTU_C = 8'h0A, SLL_C = 8'h0B;
    localparam logic [7:0] SRL_C = 8'h0C, SRA_C = 8'h0D, SRAV_C = 8'h10, LUI_C = 8'h11;
    localparam logic [7:0] CLO_C = 8'h12, CLZ_C = 8'h13, MOVZ_C = 8'h15, TEQ_C = 8'h16;
    localparam logic [7:0] TLT_C = 8'h1A, TLTU_C = 8'h1B, MFHI_C = 8'h1C, MFLO_C = 8'h1D;
    localparam logic [7:0] MTHI_C = 8'h1E, MTLO_C = 8'h1F, MULT_C = 8'h20, MULTU_C = 8'h21;
    localparam logic [7:0] DIV_C = 8'h22, DIVU_C = 8'h23, MADDU_C = 8'h25, MSUB_C = 8'h26;

    logic        clk, rst, valid_i, flush_i, overflow_o, trap_o, stall_o;
    logic [7:0]  alucontrol_i;
    logic [31:0] src_a_i, src_b_i, result_o, hi_o, lo_o;
    logic [4:0]  sa_i;
    int          n_chk, n_fail, stalls;

    alu_md_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .alucontrol_i(alucontrol_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .sa_i(sa_i), .flush_i(flush_i),
        .result_o(result_o), .overflow_o(overflow_o), .trap_o(trap_o),
        .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sa);
        @(negedge clk);
        valid_i = 1'b1; alucontrol_i = op; src_a_i = a; src_b_i = b; sa_i = sa;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_i = 1'b0; alucontrol_i = 8'h00; src_a_i = '0; src_b_i = '0;
        #1;
    endtask

    // Issue an MD op and hold it while stalled; returns in the DONE cycle.
    task automatic run_md(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int ns);
        drive(op, a, b, 5'd0);
        ns = 0;
        for (int i = 0; i < 64; i++) begin
            if (!stall_o) break;
            ns++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; alucontrol_i = '0;
        src_a_i = '0; src_b_i = '0; sa_i = '0;
        #12;
        check("reset_stall", {63'd0, stall_o}, 64'd0);
        check("reset_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk); rst = 1'b1;

        drive(ADD_C, 32'h7FFFFFFF, 32'h1, 5'd0);
        check("add_res", {32'd0, result_o}, 64'h80000000);
        check("add_ovf", {62'd0, overflow_o, stall_o}, 64'h2);
        drive(ADDU_C, 32'h7FFFFFFF, 32'h1, 5'd0);
        check("addu_ovf", {63'd0, overflow_o}, 64'd0);
        drive(SUB_C, 32'h80000000, 32'h1, 5'd0);
        check("sub", {31'd0, overflow_o, result_o}, 64'h1_7FFFFFFF);
        drive(AND_C, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        check("and", {32'd0, result_o}, 64'hF000F000);
        drive(NOR_C, 32'h0, 32'h0, 5'd0);
        check("nor", {32'd0, result_o}, 64'hFFFFFFFF);
        drive(SLT_C, 32'hFFFFFFFF, 32'h1, 5'd0);
        check("slt", {32'd0, result_o}, 64'd1);
        drive(SLTU_C, 32'hFFFFFFFF, 32'h1, 5'd0);
        check("sltu", {32'd0, result_o}, 64'd0);
        drive(SLL_C, 32'h0, 32'h1, 5'd31);
        check("sll", {32'd0, result_o}, 64'h80000000);
        drive(SRL_C, 32'h0, 32'h80000000, 5'd4);
        check("srl", {32'd0, result_o}, 64'h08000000);
        drive(SRA_C, 32'h0, 32'h80000000, 5'd4);
        check("sra", {32'd0, result_o}, 64'hF8000000);
        drive(SRAV_C, 32'h8, 32'h80000000, 5'd0);
        check("srav", {32'd0, result_o}, 64'hFF800000);
        drive(LUI_C, 32'h0, 32'h1234, 5'd0);
        check("lui", {32'd0, result_o}, 64'h12340000);
        drive(CLZ_C, 32'h00010000, 32'h0, 5'd0);
        check("clz", {32'd0, result_o}, 64'd15);
        drive(CLZ_C, 32'h0, 32'h0, 5'd0);
        check("clz_zero", {32'd0, result_o}, 64'd32);
        drive(CLO_C, 32'hFFF00000, 32'h0, 5'd0);
        check("clo", {32'd0, result_o}, 64'd12);
        drive(MOVZ_C, 32'hCAFE, 32'h0, 5'd0);
        check("movz", {32'd0, result_o}, 64'hCAFE);
        drive(TEQ_C, 32'h5, 32'h5, 5'd0);
        check("teq", {63'd0, trap_o}, 64'd1);
        drive(TLT_C, 32'hFFFFFFFF, 32'h0, 5'd0);
        check("tlt", {63'd0, trap_o}, 64'd1);
        drive(TLTU_C, 32'hFFFFFFFF, 32'h0, 5'd0);
        check("tltu", {63'd0, trap_o}, 64'd0);
        drive(8'hFF, 32'h1234, 32'h5678, 5'd3);
        check("unknown", {30'd0, overflow_o, trap_o, result_o}, 64'd0);

        run_md(MULT_C, 32'hFFFFFFFD, 32'h5, stalls);
        check("mult_stall", 64'(stalls), 64'd2);
        drive(MFLO_C, 32'h0, 32'h0, 5'd0);
        check("mult_mflo", {32'd0, result_o}, 64'hFFFFFFF1);
        check("mult_hi", {32'd0, hi_o}, 64'hFFFFFFFF);

        run_md(DIV_C, 32'hFFFFFFF9, 32'h2, stalls);
        check("div_stall", 64'(stalls), 64'd33);
        drive(MFHI_C, 32'h0, 32'h0, 5'd0);
        check("div_hilo", {result_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);

        run_md(DIVU_C, 32'h7, 32'h0, stalls);
        idle();
        check("divu_zero", {hi_o, lo_o}, 64'h00000007_FFFFFFFF);
        run_md(DIV_C, 32'h80000000, 32'hFFFFFFFF, stalls);
        idle();
        check("div_min", {hi_o, lo_o}, 64'h00000000_80000000);

        drive(MTHI_C, 32'hA, 32'h0, 5'd0);
        drive(MTLO_C, 32'hB, 32'h0, 5'd0);
        drive(DIV_C, 32'd100, 32'd7, 5'd0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("flush_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        check("flush_hilo", {hi_o, lo_o}, 64'h0000000A_0000000B);
        run_md(MULTU_C, 32'd2, 32'd3, stalls);
        check("multu_stall", 64'(stalls), 64'd2);
        idle();
        check("multu_hilo", {hi_o, lo_o}, 64'd6);

        drive(DIV_C, 32'd50, 32'd3, 5'd0);
        repeat (5) @(negedge clk);
        #1;
        check("middiv_stall", {63'd0, stall_o}, 64'd1);
        rst = 1'b0;
        #1;
        check("rst_async", {31'd0, stall_o, hi_o | lo_o}, 64'd0);
        valid_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        drive(MTLO_C, 32'h55, 32'h0, 5'd0);
        drive(MFLO_C, 32'h0, 32'h0, 5'd0);
        check("mtlo_after_rst", {lo_o, result_o}, 64'h00000055_00000055);

        drive(MTHI_C, 32'h0, 32'h0, 5'd0);
        drive(MTLO_C, 32'h10, 32'h0, 5'd0);
`ifdef ALU_MADD_EN
        run_md(MADDU_C, 32'd3, 32'd4, stalls);
        check("maddu_stall", 64'(stalls), 64'd2);
        idle();
        check("maddu_hilo", {hi_o, lo_o}, 64'h1C);
        run_md(MSUB_C, 32'd1, 32'h1D, stalls);
        idle();
        check("msub_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
`else
        drive(MADDU_C, 32'd3, 32'd4, 5'd0);
        check("maddu_off", {31'd0, stall_o, result_o}, 64'd0);
        idle();
        check("maddu_off_hilo", {hi_o, lo_o}, 64'h10);
        drive(MSUB_C, 32'd1, 32'h1D, 5'd0);
        check("msub_off_stall", {63'd0, stall_o}, 64'd0);
        idle();
        check("msub_off_hilo", {hi_o, lo_o}, 64'h10);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
